// File: rtl/pattern_serializer.sv
// Parallel-to-serial converter: one-word hold buffer, bypass load from IDLE,
// and an optional fixed idle gap between consecutive words.
module pattern_serializer #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int IDLE_BIT   = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_done,
    output logic             busy
);
    localparam int              CW         = $clog2(WIDTH);
    localparam logic            IDLE_LVL   = 1'(IDLE_BIT);
    localparam logic [CW-1:0]   LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   PENULT_IDX = CW'(WIDTH - 2);
    localparam logic [3:0]      GAP_LAST   = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] start_word;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             hold_full;
    logic             accept;
    logic             last_bit;
    logic             gap_end;
    logic             load_hold;
    logic             write_hold;
    logic             full_next;
    logic             start;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // Hold is written only outside IDLE; a word landing there on the final
    // shift/gap edge is picked up from IDLE one cycle later.
    always_comb begin
        accept     = din_valid && din_ready;
        last_bit   = (state == SHIFT) && (bit_cnt == LAST_IDX);
        gap_end    = (state == GAP) && (gap_cnt == GAP_LAST);
        load_hold  = hold_full && ((state == IDLE) || gap_end || (last_bit && GAP_CYCLES == 0));
        write_hold = accept && (state != IDLE);
        full_next  = write_hold || (hold_full && !load_hold);
        start      = load_hold || ((state == IDLE) && !hold_full && accept);
        start_word = hold_full ? hold : din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            hold       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            hold_full  <= 1'b0;
            din_ready  <= 1'b0;
            out        <= IDLE_LVL;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            hold_full  <= full_next;
            din_ready  <= !full_next;
            frame_done <= 1'b0;
            if (write_hold)
                hold <= din;
            if (start) begin
                state     <= SHIFT;
                shreg     <= advance(start_word);
                out       <= first_bit(start_word);
                out_valid <= 1'b1;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    SHIFT: begin
                        if (!last_bit) begin
                            shreg      <= advance(shreg);
                            out        <= first_bit(shreg);
                            bit_cnt    <= bit_cnt + CW'(1);
                            frame_done <= (bit_cnt == PENULT_IDX);
                        end else begin
                            state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
                            gap_cnt   <= '0;
                            out       <= IDLE_LVL;
                            out_valid <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_end)
                            state <= IDLE;
                        else
                            gap_cnt <= gap_cnt + 4'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != IDLE) || hold_full;

endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 2 to 32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 shifts the MSB out first, 0 shifts the LSB out first.
REQ-003 SHALL have parameter IDLE_BIT, default 1: level driven on out when no data bit is being shifted.
REQ-004 SHALL have parameter GAP_CYCLES, default 0: number of IDLE_BIT cycles inserted between consecutive words, legal range 0 to 15.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-008 SHALL have port din_valid, input, 1 bit: din is offered.
REQ-009 SHALL have port din_ready, output, 1 bit: the block can accept a word.
REQ-010 SHALL have port out, output, 1 bit: registered serial bit stream, intended to feed the downstream pattern detector's in port.
REQ-011 SHALL have port out_valid, output, 1 bit: out carries a data bit this cycle.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last bit of each word.
REQ-013 SHALL have port busy, output, 1 bit: high when the state is not IDLE or the hold register is full.

Function
REQ-014 SHALL contain a WIDTH-bit shift register, a bit counter, a one-entry hold register with a full flag, a gap counter, and an FSM with states IDLE, SHIFT and GAP.
REQ-015 SHALL accept a word on a rising edge where din_valid and din_ready are both 1, and SHALL drop din otherwise.
REQ-016 SHALL drive din_ready as the inverse of the registered hold-full flag only, with no combinational path from din_valid.
REQ-017 SHALL load an accepted word directly into the shifter in IDLE when the hold register is empty (bypass), entering SHIFT with the first bit on out in the cycle after the accepting edge.
REQ-018 SHALL write an accepted word into the hold register, setting the full flag, when in SHIFT or GAP.
REQ-019 SHALL, in SHIFT, present exactly one bit per cycle for WIDTH consecutive cycles with out_valid=1, in MSB_FIRST order.
REQ-020 SHALL assert frame_done for exactly the cycle in which the last bit of a word is on out.
REQ-021 SHALL handle the last-bit edge of a word as follows:
- hold full and GAP_CYCLES=0: transfer hold to the shifter, clear full, stay in SHIFT; the output stream is contiguous with no idle cycle.
- hold full and GAP_CYCLES>0: enter GAP.
- hold empty: enter GAP if GAP_CYCLES>0, else enter IDLE.
REQ-022 SHALL, in GAP, drive out=IDLE_BIT and out_valid=0 for exactly GAP_CYCLES cycles, then either load from hold into SHIFT or, if hold is empty, go to IDLE.
REQ-023 SHALL not allow a word accepted in GAP or IDLE to shorten the gap; GAP always lasts its full length.
REQ-024 SHALL, in IDLE, drive out=IDLE_BIT, out_valid=0 and frame_done=0.
REQ-025 SHALL, when hold is freed and din_valid is high on the same edge, refill hold on the next edge, because din_ready rises only after full clears.
REQ-026 SHALL present each accepted word exactly once, in acceptance order, with no loss and no duplication.

Reset
REQ-027 SHALL, while rst=1 and regardless of clk, set state=IDLE, hold-full=0, the counters to 0, out=IDLE_BIT, out_valid=0, frame_done=0, busy=0 and din_ready=0.
REQ-028 SHALL set din_ready=1 on the first clock edge after rst falls.
REQ-029 SHALL discard any word in flight or held when rst asserts mid-operation, emitting no partial remainder after release.

Verification (WIDTH=8, MSB_FIRST=1, IDLE_BIT=1, GAP_CYCLES=0 unless stated)
REQ-030 SHALL pass single word: accept 8'hA5 at edge 0 -> out=1,0,1,0,0,1,0,1 in cycles 1-8 with out_valid=1; frame_done in cycle 8 only; out=1 and busy=0 from cycle 9.
REQ-031 SHALL pass back-to-back words: 8'h00 then 8'hFF offered on consecutive cycles -> 16 contiguous valid bits (eight 0s, then eight 1s); frame_done in cycles 8 and 16.
REQ-032 SHALL pass backpressure: din_valid held high with three words -> din_ready=0 from the edge after the second accept until the first word's last bit transfers; third word emitted immediately after the second; order preserved.
REQ-033 SHALL pass gap insertion: GAP_CYCLES=2 with two words back-to-back -> exactly two out=1, out_valid=0 cycles between the words.
REQ-034 SHALL pass LSB-first: MSB_FIRST=0, 8'h01 -> out=1 followed by seven 0s.
REQ-035 SHALL pass reset mid-word: rst pulsed after 3 bits of 8'hA5 -> out=1, out_valid=0 immediately; after release, no remaining bits appear and din_ready=1 after one edge.
